// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM/UART bus controller.
// State encodings, serial-port address map and status register bit positions.
package mem_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SRAM_RD   = 3'd1,
        SRAM_WR   = 3'd2,
        UART_RD   = 3'd3,
        UART_WR   = 3'd4,
        UART_WAIT = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam logic [15:0] ADDR_SERIAL_PORT   = 16'hBF00;
    localparam logic [15:0] ADDR_SERIAL_STATUS = 16'hBF01;

    localparam int STAT_RX_READY_BIT = 0;
    localparam int STAT_TX_IDLE_BIT  = 1;

    localparam int WCNT_W = 4;

endpackage

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Strobe-length counter: loaded on request accept, decremented each strobe cycle.
// done is high while the count is zero, i.e. during the last strobe cycle.
module mem_bus_ctrl_wait_counter
    import mem_bus_ctrl_pkg::*;
#(
    parameter int W = WCNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage bus controller: one request port in front of an async SRAM and a
// memory-mapped UART, with registered strobes and configurable SRAM wait states.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                SRAM_WAIT = 1,
    parameter logic [ADDR_W-1:0] UART_ADDR = ADDR_W'(ADDR_SERIAL_PORT),
    parameter logic [ADDR_W-1:0] UART_STAT = ADDR_W'(ADDR_SERIAL_STATUS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              ram_en_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              uart_rdn,
    output logic              uart_wrn,
    input  logic              uart_data_ready,
    input  logic              uart_tbre,
    input  logic              uart_tsre,
    output state_t            dbg_state
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(SRAM_WAIT);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // req_ready is high only in IDLE; the requester holds its request while it is low.
    // resp_valid is a one-cycle pulse; resp_rdata holds until the next response.

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_done;
    logic              rdata_load;
    logic [DATA_W-1:0] rdata_next;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] wdata_q;
    logic              bus_drive;
    logic              bus_drive_d;

    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);
    assign dbg_state = state;

    assign ram_data = bus_drive ? wdata_q : {DATA_W{1'bz}};

    always_comb begin
        status_word                    = '0;
        status_word[STAT_TX_IDLE_BIT]  = uart_tbre & uart_tsre;
        status_word[STAT_RX_READY_BIT] = uart_data_ready;
    end

    mem_bus_ctrl_wait_counter #(.W(WCNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response data is loaded only on the edge entering DONE so it stays stable in between.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        rdata_load = 1'b0;
        rdata_next = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_load = 1'b1;
                    if (req_addr == UART_STAT) begin
                        state_next = DONE;
                        rdata_load = 1'b1;
                        rdata_next = req_we ? '0 : status_word;
                    end else if (req_addr == UART_ADDR) begin
                        if (req_we) begin
                            state_next = UART_WR;
                        end else if (uart_data_ready) begin
                            state_next = UART_RD;
                        end else begin
                            state_next = DONE;
                            rdata_load = 1'b1;
                        end
                    end else begin
                        state_next = req_we ? SRAM_WR : SRAM_RD;
                    end
                end
            end
            SRAM_RD: begin
                cnt_dec = !cnt_done;
                if (cnt_done) begin
                    state_next = DONE;
                    rdata_load = 1'b1;
                    rdata_next = ram_data;
                end
            end
            SRAM_WR: begin
                cnt_dec = !cnt_done;
                if (cnt_done) begin
                    state_next = DONE;
                    rdata_load = 1'b1;
                end
            end
            UART_RD: begin
                cnt_dec = !cnt_done;
                if (cnt_done) begin
                    state_next = DONE;
                    rdata_load = 1'b1;
                    rdata_next = {{(DATA_W-8){1'b0}}, ram_data[7:0]};
                end
            end
            UART_WR: begin
                state_next = UART_WAIT;
            end
            UART_WAIT: begin
                if (uart_tbre && uart_tsre) begin
                    state_next = DONE;
                    rdata_load = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Data stays on the bus for one extra cycle after a write strobe rises (hold time).
    always_comb begin
        bus_drive_d = (state_next == SRAM_WR) || (state_next == UART_WR)
                   || ((state == SRAM_WR) && (state_next == DONE))
                   || ((state == UART_WR) && (state_next == UART_WAIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en_n   <= 1'b1;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            uart_rdn   <= 1'b1;
            uart_wrn   <= 1'b1;
            bus_drive  <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            ram_en_n   <= 1'b0;
            ram_oe_n   <= !(state_next == SRAM_RD);
            ram_we_n   <= !(state_next == SRAM_WR);
            uart_rdn   <= !(state_next == UART_RD);
            uart_wrn   <= !(state_next == UART_WR);
            bus_drive  <= bus_drive_d;
            resp_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr   <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                ram_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (rdata_load) begin
                resp_rdata <= rdata_next;
            end
        end
    end

endmodule
